// File: rtl/fifo_collector.sv
// fifo_collector: round-robin drain of NUM_NODES node FIFOs into one ordered valid/ready stream
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any transfer and restarts at node 0, addr 0
//   empty      per-node FIFO empty flags (only the current node's flag is looked at)
//   rd_en      per-node read strobe, one-hot or zero; FIFO data appears on rd_data one cycle later
//   rd_data    packed node data, node i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out_data/out_addr hold a collected word
//   out_ready  sink accepts the word while out_valid is high
//   out_data   collected word
//   out_addr   sequence index of out_data, which restores the original ROM order
//   all_done   sticky, set on the edge of the final (2**ADDR_WIDTH-th) handshake
module fifo_collector #(
    parameter int NUM_NODES  = 4,
    parameter int NODE_W     = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_NODES-1:0]            empty,
    output logic [NUM_NODES-1:0]            rd_en,
    input  logic [NUM_NODES*DATA_WIDTH-1:0] rd_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic                            all_done
);
    localparam logic [NODE_W-1:0]   LAST  = NODE_W'(NUM_NODES - 1);
    // One extra bit so the word count can reach TOTAL without wrapping to 0
    localparam logic [ADDR_WIDTH:0] TOTAL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {ARB, RD, CAP, OUT, DONE} state_t;

    state_t                state, state_nxt;
    logic [NODE_W-1:0]     cur;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  hs;

    assign hs      = out_valid && out_ready;
    assign cnt_inc = cnt + 1'b1;

    // Strict round robin: ARB waits on the current node only, never skipping ahead,
    // so words leave in exactly the order they were written across the nodes.
    always_comb begin
        state_nxt = state;
        rd_en     = '0;
        case (state)
            ARB:  state_nxt = empty[cur] ? ARB : RD;
            RD: begin
                rd_en[cur] = 1'b1;
                state_nxt  = CAP;
            end
            CAP:  state_nxt = OUT;
            OUT:  state_nxt = !hs ? OUT : (cnt_inc == TOTAL) ? DONE : ARB;
            DONE: state_nxt = DONE;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            cur       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            all_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            // CAP is the cycle after the read strobe, when the FIFO's data is on rd_data
            if (state == CAP) begin
                out_data  <= rd_data[cur*DATA_WIDTH +: DATA_WIDTH];
                out_addr  <= cnt[ADDR_WIDTH-1:0];
                out_valid <= 1'b1;
            end
            if (state == OUT && hs) begin
                out_valid <= 1'b0;
                cnt       <= cnt_inc;
                cur       <= (cur == LAST) ? '0 : cur + 1'b1;
                all_done  <= all_done || (cnt_inc == TOTAL);
            end
        end
    end
endmodule

// File: tb/tb_fifo_collector.sv
// tb_fifo_collector: directed and randomized checks of fifo_collector against a timeline model
module tb_fifo_collector;
    localparam int N     = 4;
    localparam int NW    = 2;
    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int TOTAL = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      empty = '1;
    logic [N-1:0]      rd_en;
    logic [N*DW-1:0]   rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_addr;
    logic              all_done;

    fifo_collector #(.NUM_NODES(N), .NODE_W(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .rd_en(rd_en), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .all_done(all_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Model: a timeline of when the next read, capture and presentation must occur.
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    bit          m_done  = 1'b0;
    int          m_words = 0;
    int          rd_at   = -1;
    int          cap_at  = -1;
    logic [DW-1:0] m_data = '0;
    logic [AW-1:0] m_addr = '0;

    int rd_log[$];
    int rd_cyc[$];
    int hs_addr[$];
    int hs_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); rd_cyc.delete(); hs_addr.delete(); hs_data.delete();
    endtask

    // One cycle: compare DUT outputs with the model, drive this cycle's inputs, advance the model.
    task automatic step(input logic r, input logic [N-1:0] e, input logic rdy, input bit rnd);
        @(negedge clk);
        cyc++;
        chk("rd_en", rd_en, (cyc == rd_at) ? (64'd1 << (m_words % N)) : 64'd0);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_addr", out_addr, m_addr);
        chk("all_done", all_done, m_done);
        if (rd_en != '0) begin
            rd_log.push_back(int'(rd_en));
            rd_cyc.push_back(cyc);
        end
        if (r && out_valid && rdy) begin
            hs_addr.push_back(int'(out_addr));
            hs_data.push_back(int'(out_data));
        end
        rst_n = r; empty = e; out_ready = rdy;
        for (int i = 0; i < N; i++)
            rd_data[i*DW +: DW] = rnd ? DW'($urandom) : DW'(16'hA000 + i);
        if (!r) begin
            m_idle = 1; m_valid = 0; m_done = 0; m_words = 0;
            rd_at = -1; cap_at = -1; m_data = '0; m_addr = '0;
        end else if (m_idle && !e[m_words % N]) begin
            m_idle = 0; rd_at = cyc + 1; cap_at = cyc + 2;
        end else if (cyc == cap_at) begin
            m_valid = 1; m_data = rd_data[(m_words % N)*DW +: DW]; m_addr = AW'(m_words);
        end else if (m_valid && rdy) begin
            m_valid = 0; m_words++;
            if (m_words == TOTAL) m_done = 1; else m_idle = 1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_done", all_done, 0);
        // 1: reset held with random inputs
        for (int i = 0; i < 5; i++) step(0, N'($urandom), 1'($urandom), 1);

        // 2: everything available, sink always ready
        clear_logs();
        for (int i = 0; i < 20; i++) step(1, '0, 1, 0);
        chk("t2_nreads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("t2_rd", rd_log[i], 1 << i);
        for (int i = 1; i < 4 && i < rd_cyc.size(); i++) chk("t2_gap", rd_cyc[i] - rd_cyc[i-1], 4);
        chk("t2_nwords", hs_addr.size(), 4);
        for (int i = 0; i < 4 && i < hs_addr.size(); i++) begin
            chk("t2_addr", hs_addr[i], i);
            chk("t2_data", hs_data[i], 16'hA000 + i);
        end
        chk("t2_done", all_done, 1);

        // 6: after completion nothing more is read
        clear_logs();
        for (int i = 0; i < 20; i++) step(1, '0, 1, 1);
        chk("t6_noreads", rd_log.size(), 0);
        chk("t6_done", all_done, 1);

        // 3: node 1 empty after word 0
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        clear_logs();
        for (int i = 0; i < 20 && hs_addr.size() < 1; i++) step(1, 4'b0010, 1, 0);
        chk("t3_word0", hs_addr.size(), 1);
        for (int i = 0; i < 10; i++) step(1, 4'b0010, 1, 0);
        chk("t3_hold_reads", rd_log.size(), 1);
        chk("t3_hold_valid", out_valid, 0);
        for (int i = 0; i < 10 && rd_log.size() < 2; i++) step(1, '0, 0, 0);
        chk("t3_rd1", (rd_log.size() >= 2) ? rd_log[1] : 0, 4'b0010);

        // 4: sink stalls with word 1 valid
        for (int i = 0; i < 10 && !out_valid; i++) step(1, '0, 0, 0);
        chk("t4_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) step(1, '0, 0, 0);
        chk("t4_addr", out_addr, 1);
        chk("t4_data", out_data, 16'hA001);
        chk("t4_noreads", rd_log.size(), 2);
        for (int i = 0; i < 10 && rd_log.size() < 3; i++) step(1, '0, 1, 0);
        chk("t4_rd2", (rd_log.size() >= 3) ? rd_log[2] : 0, 4'b0100);
        chk("t4_hs_addr", (hs_addr.size() >= 2) ? hs_addr[1] : -1, 1);

        // 5: reset in the capture cycle of word 2
        step(0, '0, 1, 0);
        #1;
        chk("t5_async_addr", out_addr, 0);
        chk("t5_async_data", out_data, 0);
        chk("t5_async_valid", out_valid, 0);
        step(0, '0, 1, 0);
        clear_logs();
        for (int i = 0; i < 20 && hs_addr.size() < 1; i++) step(1, '0, 1, 1);
        chk("t5_rd", (rd_log.size() >= 1) ? rd_log[0] : 0, 4'b0001);
        chk("t5_addr", (hs_addr.size() >= 1) ? hs_addr[0] : -1, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] e;
            for (int b = 0; b < N; b++) e[b] = ($urandom_range(0, 9) < 3);
            step($urandom_range(0, 199) != 0, e, $urandom_range(0, 9) < 7, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
